// File: rtl/i2c_mon_pkg.sv
// Shared types and default sizing for the I2C lock-step mismatch monitor.
package i2c_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WATCH = 2'd1,
        HOLD  = 2'd2
    } mon_state_t;

    localparam int DEF_WINDOW_CYCLES   = 1024;
    localparam int DEF_MISMATCH_THRESH = 3;
    localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/i2c_sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; clear beats increment.
module i2c_sat_counter #(
    parameter int             W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_val
);

    logic [W-1:0] r_val;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_val <= '0;
        end else if (i_inc && (r_val != MAX)) begin
            r_val <= r_val + 1'b1;
        end
    end

    assign o_val = r_val;

endmodule

// File: rtl/i2c_mismatch_monitor.sv
// Watches the lock-step checker verdict over fixed windows, counts mismatches and
// latches a sticky alarm once a run of consecutive mismatches reaches the threshold.
module i2c_mismatch_monitor
    import i2c_mon_pkg::*;
#(
    parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
    parameter int MISMATCH_THRESH = DEF_MISMATCH_THRESH,
    parameter int CNT_W           = DEF_CNT_W,
    localparam int OFF_W          = $clog2(WINDOW_CYCLES),
    localparam int CONS_W         = $clog2(MISMATCH_THRESH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_match,
    input  logic             i_clear,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_alarm,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_first_err_valid,
    output logic [OFF_W-1:0] o_first_err_off,
    output logic [1:0]       o_state
);

    mon_state_t         r_state;
    logic [OFF_W-1:0]   r_off;
    logic               r_win_err;
    logic               r_done;
    logic               r_pass;
    logic               r_alarm;
    logic               r_first_valid;
    logic [OFF_W-1:0]   r_first_off;

    logic               w_watch;
    logic               w_mis;
    logic               w_last;
    logic               w_hit;
    logic               w_cons_clr;
    logic [CONS_W-1:0]  w_cons;

    assign w_watch    = (r_state == WATCH);
    assign w_mis      = w_watch && !i_match;
    assign w_last     = (r_off == OFF_W'(WINDOW_CYCLES - 1));
    // A restart or clear in the same cycle suppresses the alarm for that sample.
    assign w_hit      = w_mis && !i_start && !i_clear
                        && (w_cons == CONS_W'(MISMATCH_THRESH - 1));
    assign w_cons_clr = i_clear || i_start || !w_watch || i_match;

    i2c_sat_counter #(
        .W   (CNT_W),
        .MAX ('1)
    ) u_err_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clear),
        .i_inc (w_mis),
        .o_val (o_err_count)
    );

    i2c_sat_counter #(
        .W   (CONS_W),
        .MAX (CONS_W'(MISMATCH_THRESH))
    ) u_cons_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_cons_clr),
        .i_inc (w_mis),
        .o_val (w_cons)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_off         <= '0;
            r_win_err     <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_alarm       <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_off   <= '0;
        end else begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state   <= WATCH;
                        r_off     <= '0;
                        r_win_err <= 1'b0;
                    end
                end
                WATCH: begin
                    if (w_hit) begin
                        r_state <= HOLD;
                    end else if (i_start) begin
                        r_off     <= '0;
                        r_win_err <= 1'b0;
                    end else if (w_last) begin
                        // The last-cycle mismatch must count against pass.
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_pass  <= !(r_win_err || w_mis);
                    end else begin
                        r_off <= r_off + 1'b1;
                        if (w_mis) begin
                            r_win_err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (i_clear) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (i_clear) begin
                r_alarm <= 1'b0;
            end else if (w_hit) begin
                r_alarm <= 1'b1;
            end

            if (i_clear) begin
                r_first_valid <= 1'b0;
            end else if (w_mis && !r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_off   <= r_off;
            end
        end
    end

    assign o_busy            = w_watch;
    assign o_done            = r_done;
    assign o_pass            = r_pass;
    assign o_alarm           = r_alarm;
    assign o_first_err_valid = r_first_valid;
    assign o_first_err_off   = r_first_off;
    assign o_state           = r_state;

endmodule
